// File: rtl/score_text_ctrl_pkg.sv
// Shared types and constants for the score text controller.
// Holds the state encoding, ASCII codes and the double-dabble step.
package score_text_ctrl_pkg;

   localparam logic [6:0] ASCII_ZERO  = 7'h30;
   localparam logic [6:0] ASCII_SPACE = 7'h20;
   localparam int         SCORE_MAX   = 99;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADD,
      S_CONV,
      S_WAIT_VB,
      S_WR_TENS,
      S_WR_ONES
   } score_ctrl_state_t;

   // {tens, ones, bin}: correct BCD nibbles, then shift left by one
   function automatic logic [14:0] dd_step(input logic [14:0] v);
      logic [14:0] t;
      t = v;
      if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
      if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
      return {t[13:0], 1'b0};
   endfunction

endpackage

// File: rtl/score_text_ctrl.sv
// Two-digit saturating score with iterative BCD conversion and
// vblank-timed writes of the two ASCII characters into char RAM.
module score_text_ctrl
   import score_text_ctrl_pkg::*;
#(
   parameter int MAX_SCORE     = SCORE_MAX,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_start,
   input  logic       hit_pulse,
   input  logic [2:0] hit_points,
   input  logic       vblank,
   output logic [6:0] score,
   output logic       text_we,
   output logic       text_addr,
   output logic [6:0] text_data,
   output logic       busy
);

   localparam logic [7:0] MAX8 = 8'(MAX_SCORE);

   score_ctrl_state_t state_q;
   logic [6:0]  score_q, pend_q, pend_d, sh_q;
   logic [7:0]  bcd_q;
   logic [2:0]  cnt_q;
   logic        clr_q, clr_d;
   logic        we_q, addr_q, busy_q;
   logic [6:0]  data_q;
   logic [6:0]  base, add_score;
   logic [7:0]  sum, psum;
   logic [14:0] dd;

   function automatic logic [6:0] tens_chr(input logic [3:0] t);
      if (t == 4'd0 && BLANK_LEADING) return ASCII_SPACE;
      return ASCII_ZERO + {3'b000, t};
   endfunction

   assign base      = clr_q ? 7'd0 : score_q;
   assign sum       = {1'b0, base} + {1'b0, pend_q};
   assign add_score = (sum > MAX8) ? MAX8[6:0] : sum[6:0];
   assign psum      = {1'b0, pend_q} + {5'b00000, hit_points};
   assign dd        = dd_step({bcd_q, sh_q});

   // ADD consumes pending; a hit in that same cycle starts a fresh batch
   always_comb begin
      pend_d = pend_q;
      clr_d  = clr_q;
      if (state_q == S_ADD) begin
         pend_d = '0;
         clr_d  = 1'b0;
      end
      if (hit_pulse) begin
         if (state_q == S_ADD) pend_d = {4'b0000, hit_points};
         else pend_d = psum[7] ? 7'h7f : psum[6:0];
      end
      if (game_start) begin
         pend_d = '0;
         clr_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         score_q <= '0;
         pend_q  <= '0;
         clr_q   <= 1'b1;
         sh_q    <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= 1'b0;
         data_q  <= ASCII_SPACE;
         busy_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         clr_q  <= clr_d;
         we_q   <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (clr_d || pend_d != 7'd0) begin
                  state_q <= S_ADD;
                  busy_q  <= 1'b1;
               end
            end
            S_ADD: begin
               score_q <= add_score;
               sh_q    <= add_score;
               bcd_q   <= '0;
               cnt_q   <= '0;
               state_q <= S_CONV;
            end
            S_CONV: begin
               bcd_q <= dd[14:7];
               sh_q  <= dd[6:0];
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q == 3'd6) begin
                  if (vblank) begin
                     state_q <= S_WR_TENS;
                     we_q    <= 1'b1;
                     addr_q  <= 1'b0;
                     data_q  <= tens_chr(dd[14:11]);
                  end else begin
                     state_q <= S_WAIT_VB;
                  end
               end
            end
            S_WAIT_VB: begin
               if (vblank) begin
                  state_q <= S_WR_TENS;
                  we_q    <= 1'b1;
                  addr_q  <= 1'b0;
                  data_q  <= tens_chr(bcd_q[7:4]);
               end
            end
            S_WR_TENS: begin
               state_q <= S_WR_ONES;
               we_q    <= 1'b1;
               addr_q  <= 1'b1;
               data_q  <= ASCII_ZERO + {3'b000, bcd_q[3:0]};
            end
            S_WR_ONES: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign score     = score_q;
   assign text_we   = we_q;
   assign text_addr = addr_q;
   assign text_data = data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_score_text_ctrl.sv
// Bench for score_text_ctrl: directed and random hits against an
// arithmetic score model and a log of char RAM writes.
module tb_score_text_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       game_start = 1'b0;
   logic       hit_pulse = 1'b0;
   logic [2:0] hit_points = 3'd0;
   logic       vblank = 1'b1;
   logic [6:0] score;
   logic       text_we;
   logic       text_addr;
   logic [6:0] text_data;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int model = 0;
   int qa[$];
   int qd[$];
   int qc[$];

   score_text_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .game_start (game_start),
      .hit_pulse  (hit_pulse),
      .hit_points (hit_points),
      .vblank     (vblank),
      .score      (score),
      .text_we    (text_we),
      .text_addr  (text_addr),
      .text_data  (text_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (text_we === 1'b1) begin
         qa.push_back(int'(text_addr));
         qd.push_back(int'(text_data));
         qc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   function automatic int tens_ch(input int s);
      return (s / 10 == 0) ? 32'h20 : 32'h30 + s / 10;
   endfunction

   function automatic int ones_ch(input int s);
      return 32'h30 + s % 10;
   endfunction

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 60) begin
         step();
         k++;
      end
      if (k >= 60) chk("idle_timeout", busy, 0);
   endtask

   task automatic wait_pairs(input int n, input int budget);
      int k;
      k = 0;
      while (qa.size() < 2 * n && k < budget) begin
         step();
         k++;
      end
      chk("write_count", qa.size(), 2 * n);
   endtask

   task automatic chk_pair(input string tag, input int s, input int tc);
      if (qa.size() >= 2) begin
         chk({tag, "_a0"}, qa[0], 0);
         chk({tag, "_tens"}, qd[0], tens_ch(s));
         chk({tag, "_a1"}, qa[1], 1);
         chk({tag, "_ones"}, qd[1], ones_ch(s));
         chk({tag, "_consec"}, qc[1] - qc[0], 1);
         if (tc >= 0) chk({tag, "_cyc"}, qc[0], tc);
         void'(qa.pop_front()); void'(qa.pop_front());
         void'(qd.pop_front()); void'(qd.pop_front());
         void'(qc.pop_front()); void'(qc.pop_front());
      end else begin
         chk({tag, "_missing"}, qa.size(), 2);
      end
   endtask

   task automatic do_hit(input int hp, input string tag);
      int hc;
      wait_idle();
      hc = cyc;
      hit_pulse = 1'b1;
      hit_points = 3'(hp);
      step();
      hit_pulse = 1'b0;
      model = (model + hp > 99) ? 99 : model + hp;
      wait_pairs(1, 40);
      chk_pair(tag, model, hc + 9);
      chk({tag, "_score"}, score, model);
   endtask

   task automatic do_clear(input string tag);
      int hc;
      wait_idle();
      hc = cyc;
      game_start = 1'b1;
      step();
      game_start = 1'b0;
      model = 0;
      wait_pairs(1, 40);
      chk_pair(tag, 0, hc + 9);
      chk({tag, "_score"}, score, 0);
   endtask

   initial begin
      int k;
      repeat (3) step();
      chk("rst_score", score, 0);
      chk("rst_we", text_we, 0);
      chk("rst_addr", text_addr, 0);
      chk("rst_data", text_data, 32'h20);
      chk("rst_busy", busy, 0);

      rst = 1'b1;
      wait_pairs(1, 40);
      chk_pair("boot", 0, -1);
      chk("boot_score", score, 0);

      do_hit(5, "hit5");

      do_clear("clr1");
      repeat (13) do_hit(7, "ramp");
      do_hit(6, "to97");
      do_hit(7, "sat99");
      do_hit(3, "sat99b");

      do_clear("clr2");
      repeat (12) do_hit(int'($urandom_range(1, 7)), "rnd");

      // Three hits while the first update waits for vblank
      do_clear("clr3");
      vblank = 1'b0;
      wait_idle();
      hit_pulse = 1'b1;
      hit_points = 3'd4;
      step();
      hit_pulse = 1'b0;
      repeat (3) step();
      hit_pulse = 1'b1;
      step();
      hit_pulse = 1'b0;
      repeat (8) step();
      chk("wait_vb_busy", busy, 1);
      chk("wait_vb_nowr", qa.size(), 0);
      hit_pulse = 1'b1;
      step();
      hit_pulse = 1'b0;
      repeat (3) step();
      vblank = 1'b1;
      model = 12;
      wait_pairs(2, 80);
      chk_pair("acc_first", 4, -1);
      chk_pair("acc_second", 12, -1);
      chk("acc_score", score, 12);

      do_clear("clr4");
      repeat (5) do_hit(7, "to35");
      do_hit(5, "to40");
      wait_idle();
      game_start = 1'b1;
      hit_pulse = 1'b1;
      hit_points = 3'd7;
      step();
      game_start = 1'b0;
      hit_pulse = 1'b0;
      model = 0;
      wait_pairs(1, 40);
      chk_pair("gs_hit", 0, -1);
      chk("gs_hit_score", score, 0);
      repeat (20) step();
      chk("gs_no_extra", qa.size(), 0);

      // Reset while the tens character is being written
      wait_idle();
      hit_pulse = 1'b1;
      hit_points = 3'd3;
      step();
      hit_pulse = 1'b0;
      k = 0;
      while (text_we !== 1'b1 && k < 30) begin
         step();
         k++;
      end
      chk("mid_we_seen", text_we, 1);
      chk("mid_addr", text_addr, 0);
      rst = 1'b0;
      #1;
      chk("mid_rst_we", text_we, 0);
      chk("mid_rst_data", text_data, 32'h20);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_score", score, 0);
      step();
      step();
      chk("mid_rst_hold_we", text_we, 0);
      qa.delete();
      qd.delete();
      qc.delete();
      rst = 1'b1;
      model = 0;
      wait_pairs(1, 40);
      chk_pair("redraw", 0, -1);
      chk("redraw_score", score, 0);
      repeat (20) step();
      chk("redraw_no_extra", qa.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_text_ctrl.md
# score_text_ctrl

Sequential controller that owns the on-screen two-digit score. It accumulates hit events into a saturating 0..99 score and converts the score to two decimal digits with an iterative shift-add-3 (double-dabble) engine. During vertical blanking it writes the two ASCII characters, one per cycle, into the two-entry character RAM that feeds the score overlay's character/font path. It sits between the game logic (hit source) and the score-drawing chain, replacing the direct combinational binary-to-ASCII hookup.

## Interface
- MAX_SCORE, 99: saturation ceiling, must be ≤ 99.
- BLANK_LEADING, 1: 1 = tens digit 0 shown as space (0x20); 0 = shown as '0' (0x30).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous assert, active-low, synchronous deassert handled upstream.
- game_start  in  1  one-cycle pulse: clear score to 0 and redraw.
- hit_pulse  in  1  one-cycle pulse: add hit_points to score.
- hit_points  in  3  points per hit, 0..7.
- vblank  in  1  level, high during vertical blanking (from vga_if timing).
- score  out  7  current binary score.
- text_we  out  1  char RAM write strobe.
- text_addr  out  1  char index: 0 = tens, 1 = ones.
- text_data  out  7  ASCII code to write.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ADD, CONV, WAIT_VB, WR_TENS, WR_ONES.
- IDLE: if clear_req → ADD (score forced 0); else if pending ≠ 0 → ADD; else stay.
- ADD: score ← min(score + pending, MAX_SCORE), 8-bit intermediate sum. pending ← 0, unless a hit arrives in the same cycle, in which case pending ← hit_points. Then → CONV.
- CONV: 7 iterations of double-dabble on the 7-bit score into two 4-bit BCD nibbles. Before each shift, add 3 to any nibble ≥ 5. After the 7th iteration → WAIT_VB.
- WAIT_VB: stay until vblank = 1, then → WR_TENS.
- WR_TENS: text_we = 1, text_addr = 0, text_data = tens char, → WR_ONES.
- WR_ONES: text_we = 1, text_addr = 1, text_data = 0x30 + ones, → IDLE.
- Tens char: 0x20 if tens = 0 and BLANK_LEADING = 1; otherwise 0x30 + tens.
- Pending accumulator, 7 bits: hit_pulse in any state adds hit_points, saturating at 127. Hits are never lost while busy.
- game_start in any state sets clear_req. It is applied in the next IDLE→ADD and clears pending. If game_start and hit_pulse coincide, the hit is dropped.
- An update that spans a vblank that ends mid-write still completes both writes on consecutive cycles.

## Timing
- Reset values: score = 0, text_we = 0, text_addr = 0, text_data = 0x20, busy = 0, state = IDLE, pending = 0, clear_req = 1.
- After reset, the first IDLE cycle performs a clear/redraw, so the RAM holds " 0" (BLANK_LEADING = 1) after the first vblank.
- Hit at cycle n while IDLE: pending is set at n+1, ADD runs at n+1, score is valid at n+2, CONV occupies n+2..n+8, WAIT_VB starts at n+9.
- If vblank is already high: WR_TENS at n+9, WR_ONES at n+10, IDLE at n+11.
- text_we is high for exactly 2 consecutive cycles per update, never otherwise.
- Reset asserted mid-update: everything returns to reset values immediately. No further writes occur until the post-reset redraw.

## Structure
- Add to vga_pkg: ASCII_ZERO = 7'h30, ASCII_SPACE = 7'h20, the state enum typedef score_ctrl_state_t, and SCORE_MAX = 99.
- One natural sub-module, bcd_dd_iter: a 7-bit iterative double-dabble with start/done. The FSM may also inline it.
- The existing char_ram write port is driven by text_we, text_addr and text_data.

## Test plan
- Reset, vblank held high → one write pair (0, 0x20), (1, 0x30); score = 0.
- hit_points = 5, pulse once → score = 5; writes 0x20, 0x35 exactly at cycles n+9 and n+10.
- Score 97, hit of 7 → score saturates at 99; writes 0x39, 0x39.
- vblank low, three hits of 4 during CONV/WAIT_VB → the first update writes the first value; the second update adds the accumulated 8 with no loss. Final score = 12; last writes 0x31, 0x32.
- game_start coincident with hit_pulse at score 40 → score = 0, writes 0x20, 0x30, hit ignored.
- rst asserted during WR_TENS → text_we drops the same cycle. Outputs return to reset values; the redraw follows after deassert.
